// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with 256-bit lines.
// Hits complete combinationally; misses stall the pipeline while lines move over a req/ack port.
module dcache_ctrl #(
  parameter int NUM_LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  rdata_o,
  output logic         stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [1:0]   dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 27 - IDX_W;

  // Memory handshake: mem_enable_o/mem_write_o/mem_addr_o/mem_data_o are held
  // stable from the cycle a phase starts until the cycle mem_ack_i is seen
  // high at a clock edge; mem_ack_i is only honoured in WB and FILL.
  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  state_t               state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       word_sel;
  logic [255:0]     line;
  logic [31:0]      rd_word;
  logic             hit;
  logic             victim_dirty;
  logic             access_done;
  logic             store_commit;
  logic             fill_commit;
  logic             unused_addr_bits;

  assign idx              = addr_i[5 +: IDX_W];
  assign req_tag          = addr_i[31 -: TAG_W];
  assign word_sel         = addr_i[4:2];
  assign unused_addr_bits = ^addr_i[1:0];

  assign line         = data_q[idx];
  assign rd_word      = line[{word_sel, 5'b0} +: 32];
  assign hit          = req_i & valid_q[idx] & (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];

  // DONE always finishes the held request against the freshly filled line.
  assign access_done  = req_i & (((state_q == S_IDLE) & hit) | (state_q == S_DONE));
  assign store_commit = access_done & we_i;
  assign fill_commit  = (state_q == S_FILL) & mem_ack_i;

  assign stall_o     = ((state_q == S_IDLE) & req_i & ~hit) |
                       (state_q == S_WB) | (state_q == S_FILL);
  assign rdata_o     = (access_done & ~we_i) ? rd_word : 32'h0;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= 32'h0;
      mem_data_o   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i && !hit) begin
            mem_enable_o <= 1'b1;
            if (victim_dirty) begin
              state_q     <= S_WB;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_q[idx], idx, 5'b0};
              mem_data_o  <= line;
            end else begin
              state_q     <= S_FILL;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {addr_i[31:5], 5'b0};
              mem_data_o  <= '0;
            end
          end
        end
        S_WB: begin
          if (mem_ack_i) begin
            state_q     <= S_FILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {addr_i[31:5], 5'b0};
            mem_data_o  <= '0;
          end
        end
        S_FILL: begin
          if (mem_ack_i) begin
            state_q      <= S_DONE;
            mem_enable_o <= 1'b0;
            mem_addr_o   <= 32'h0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_commit) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (store_commit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone gates their use.
  always_ff @(posedge clk_i) begin
    if (fill_commit) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx]  <= req_tag;
    end else if (store_commit) begin
      data_q[idx][{word_sel, 5'b0} +: 32] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random accesses checked against a
// word-level golden memory, a hit/miss/dirty cache model and an off-chip memory responder.
module tb_dcache_ctrl;

  localparam int NL    = 32;
  localparam int IDX_W = 5;
  localparam int TAG_W = 22;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [31:0]  addr = 32'h0;
  logic [31:0]  wdata = 32'h0;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_en;
  logic         mem_wr;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  dcache_ctrl #(.NUM_LINES(NL)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall), .mem_enable_o(mem_en),
    .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack), .dbg_state_o(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  bit abort    = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Off-chip memory, golden CPU-visible words, and expected cache occupancy.
  logic [255:0]     mem_model [logic [26:0]];
  logic [31:0]      gold      [logic [29:0]];
  logic             mvalid [NL];
  logic             mdirty [NL];
  logic [TAG_W-1:0] mtag   [NL];
  logic [26:0]      exp_wb_q[$];
  logic [255:0]     exp_wbd_q[$];
  logic [26:0]      exp_fill_q[$];
  int lw_cfg = 1;
  int lr_cfg = 1;
  int wait_cnt = 0;

  function automatic logic [255:0] mem_line(input logic [26:0] la);
    logic [255:0] l;
    logic [31:0]  key;
    if (mem_model.exists(la)) return mem_model[la];
    for (int w = 0; w < 8; w++) begin
      key = {2'b0, la, 3'(w)};
      l[w*32 +: 32] = (key * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    end
    return l;
  endfunction

  function automatic logic [31:0] gold_word(input logic [29:0] wa);
    logic [255:0] l;
    if (gold.exists(wa)) return gold[wa];
    l = mem_line(wa[29:3]);
    return l[wa[2:0]*32 +: 32];
  endfunction

  function automatic logic [255:0] gold_line(input logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_word({la, 3'(w)});
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    gold.delete();
    exp_wb_q.delete();
    exp_wbd_q.delete();
    exp_fill_q.delete();
  endtask

  // Classify one access and queue the memory traffic it must cause.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input int lw, input int lr,
                              output int exp_stall, output logic [31:0] exp_rd);
    int i;
    logic [TAG_W-1:0] t;
    i = int'(a[5 +: IDX_W]);
    t = a[31 -: TAG_W];
    exp_rd = 32'h0;
    if (mvalid[i] && mtag[i] == t) begin
      exp_stall = 0;
    end else begin
      if (mvalid[i] && mdirty[i]) begin
        exp_wb_q.push_back({mtag[i], 5'(i)});
        exp_wbd_q.push_back(gold_line({mtag[i], 5'(i)}));
        exp_stall = lw + lr + 1;
      end else begin
        exp_stall = lr + 1;
      end
      exp_fill_q.push_back(a[31:5]);
      mvalid[i] = 1'b1;
      mdirty[i] = 1'b0;
      mtag[i]   = t;
    end
    if (w) begin
      gold[a[31:2]] = d;
      mdirty[i] = 1'b1;
    end else begin
      exp_rd = gold_word(a[31:2]);
    end
  endtask

  // Memory responder: acks after lw_cfg/lr_cfg cycles of each phase (1 = zero wait states).
  initial begin
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst_n || !mem_en) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= (mem_wr ? lw_cfg : lr_cfg)) begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          if (mem_wr) begin
            check_eq("wb_expected", exp_wb_q.size() != 0, 1);
            if (exp_wb_q.size() != 0) begin
              check_eq("wb_addr", mem_addr, {exp_wb_q.pop_front(), 5'b0});
              check_eq("wb_data", mem_wdata, exp_wbd_q.pop_front());
            end
            mem_model[mem_addr[31:5]] = mem_wdata;
          end else begin
            check_eq("fill_expected", exp_fill_q.size() != 0, 1);
            if (exp_fill_q.size() != 0)
              check_eq("fill_addr", mem_addr, {exp_fill_q.pop_front(), 5'b0});
            mem_rdata = mem_line(mem_addr[31:5]);
          end
        end
      end
    end
  end

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int lw, input int lr);
    int exp_stall;
    int n;
    logic [31:0] exp_rd;
    if (abort) return;
    model_access(w, a, d, lw, lr, exp_stall, exp_rd);
    @(negedge clk);
    lw_cfg = lw;
    lr_cfg = lr;
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    #1;
    n = 0;
    while (stall && n < 300) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (n >= 300) begin
      check_eq("stall_timeout", 1, 0);
      abort = 1'b1;
    end
    check_eq("stall_cycles", n, exp_stall);
    if (!w) check_eq("load_data", rdata, exp_rd);
    check_eq("wb_pending", exp_wb_q.size(), 0);
    check_eq("fill_pending", exp_fill_q.size(), 0);
    @(negedge clk);
    req = 1'b0;
    we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_en"}, mem_en, 0);
    check_eq({tag, "_mem_wr"}, mem_wr, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_data"}, mem_wdata, 0);
    check_eq({tag, "_stall"}, stall, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    logic [255:0] l0;
    logic [31:0]  ra;
    int           exp_stall;
    logic [31:0]  exp_rd;

    model_reset();
    l0 = mem_line(27'h0);
    l0[63:32] = 32'hDEAD_BEEF;
    mem_model[27'h0] = l0;

    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Cold load, 10-cycle fill, then repeat hit.
    do_access(1'b0, 32'h0000_0004, 32'h0, 1, 10);
    do_access(1'b0, 32'h0000_0004, 32'h0, 1, 1);
    // Store hit and read-back.
    do_access(1'b1, 32'h0000_0008, 32'h1234_5678, 1, 1);
    do_access(1'b0, 32'h0000_0008, 32'h0, 1, 1);
    // Dirty eviction of line 0, then the evicted address returns clean.
    do_access(1'b0, 32'h0000_0400, 32'h0, 2, 3);
    do_access(1'b0, 32'h0000_0000, 32'h0, 2, 2);
    do_access(1'b0, 32'h0000_0008, 32'h0, 1, 1);
    // Store miss on line 1, then evict it.
    do_access(1'b1, 32'h0000_0024, 32'hCAFE_F00D, 1, 4);
    do_access(1'b0, 32'h0000_0424, 32'h0, 3, 2);
    do_access(1'b0, 32'h0000_0024, 32'h0, 1, 1);
    // Zero wait states on both phases of a dirty miss.
    do_access(1'b1, 32'h0000_0800, 32'hA5A5_1111, 1, 1);
    do_access(1'b0, 32'h0000_0C04, 32'h0, 1, 1);
    do_access(1'b0, 32'h0000_0800, 32'h0, 1, 1);
    // Last index.
    do_access(1'b1, 32'h0000_03FC, 32'h0BAD_CAFE, 1, 2);
    do_access(1'b0, 32'h0000_07E0, 32'h0, 2, 1);
    do_access(1'b0, 32'h0000_03FC, 32'h0, 1, 1);

    // Reset in the middle of a fill.
    if (!abort) begin
      ra = 32'h0000_1044;
      model_access(1'b0, ra, 32'h0, 1, 20, exp_stall, exp_rd);
      @(negedge clk);
      lr_cfg = 20;
      req = 1'b1;
      we = 1'b0;
      addr = ra;
      repeat (6) @(negedge clk);
      #1;
      check_eq("mid_fill_stall", stall, 1);
      check_eq("mid_fill_mem_en", mem_en, 1);
      #1;
      rst_n = 1'b0;
      req = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_access(1'b0, ra, 32'h0, 1, 3);
      do_access(1'b0, ra, 32'h0, 1, 1);
    end

    // Random traffic concentrated on a few conflicting indices and tags.
    for (int k = 0; k < 400; k++) begin
      logic [TAG_W-1:0] t;
      logic [IDX_W-1:0] ix;
      logic [31:0]      a;
      case ($urandom_range(0, 3))
        0:       ix = 5'd0;
        1:       ix = 5'd1;
        2:       ix = 5'd31;
        default: ix = 5'($urandom_range(0, NL - 1));
      endcase
      t = TAG_W'($urandom_range(0, 3));
      a = {t, ix, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
